serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller. It sequences one 1-bit full-adder datapath (sum = a^b^c, carry = majority) over WIDTH-bit operands, LSB first, one bit per clock.
- It accepts operands through a start/ready handshake, holds the carry in a flop between bit slices, and presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- It is the area-minimal alternative to a ripple chain of full adders in the lab datapath.

---
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice swept LSB-first over WIDTH-bit operands.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic g, p;

  assign g  = a & b;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = g | (p & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } ops_t;

  state_t           state, state_nxt;
  ops_t             ops;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             s_bit;
  logic             c_nxt;
  logic             last;

  serial_adder_fa u_fa (
    .a  (ops.op_a[0]),
    .b  (ops.op_b[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_nxt)
  );

  // New sum bit enters at the MSB so the final shift leaves the result aligned.
  generate
    if (WIDTH == 1) begin : g_sh1
      assign shreg_nxt = s_bit;
    end else begin : g_shn
      assign shreg_nxt = {s_bit, shreg[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ADD;
      S_ADD:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_ADD:   busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // Result registers only move on the last slice; they hold across the next ADD.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ops.op_a <= a;
            ops.op_b <= b;
            carry    <= cin;
            cnt      <= '0;
            shreg    <= '0;
          end
        end
        S_ADD: begin
          ops.op_a <= ops.op_a >> 1;
          ops.op_b <= ops.op_b >> 1;
          carry    <= c_nxt;
          shreg    <= shreg_nxt;
          cnt      <= cnt + CW'(1);
          if (last) begin
            sum  <= shreg_nxt;
            cout <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= carry ^ c_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model plus directed vectors.

module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 computing, 2 result cycle.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [8:0]  m_pend  = '0;
  logic [7:0]  m_sum   = '0;
  logic        m_cout  = 1'b0;
  logic        m_povf  = 1'b0;
  logic        m_ovf   = 1'b0;
  bit          chk_en  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; chk_en = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          int ss;
          m_pend = {1'b0, a} + {1'b0, b} + {8'b0, cin};
          ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
          m_povf = (ss > 127) || (ss < -128);
          m_left = WIDTH;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_sum = m_pend[7:0]; m_cout = m_pend[8]; m_ovf = m_povf; m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, m_phase == 0);
      chk("busy",  busy,  m_phase == 1);
      chk("done",  done,  m_phase == 2);
      chk("sum",   sum,   m_sum);
      chk("cout",  cout,  m_cout);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf",   ovf,   m_ovf);
`endif
    end
  end

  // Launch one op at a negedge and wait (bounded) for done; optionally scramble inputs meanwhile.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic oc,
                        input logic [7:0] es, input logic ec, input bit scramble,
                        input string tag);
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    a = oa; b = ob; cin = oc; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      if (done) begin got = 1; break; end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_latency"}, lat, WIDTH + 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, "t5a3c");
    @(negedge clk);
    chk("ready_after_done", ready, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "tff01");
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, "tff00c");

    // Start held high: one result per WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("held_sum", sum, 8'h30);
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 3);
    repeat (12) @(negedge clk);

    run_op(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1, "scramble");
    a = 8'h00; b = 8'h00; cin = 1'b0;

    // Reset on the 4th ADD cycle discards the operation.
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_cout", cout, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, "t0101");

`ifdef SERIAL_ADD_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, "ovf7f");
    chk("ovf7f_ovf", ovf, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, "ovf80");
    chk("ovf80_ovf", ovf, 1'b1);
    run_op(8'h40, 8'h20, 1'b0, 8'h60, 1'b0, 0, "ovf40");
    chk("ovf40_ovf", ovf, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
